uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Round-robin scheduler that shares the single UART transmitter inside `uart_top` between `N_REQ` byte producers. It arbitrates pending requests, latches the winner's byte, and pulses `tx_en` for one cycle. It then waits for the transmitter's completion, acknowledges the requester, and enforces an inter-byte idle gap. A watchdog covers the case where completion never arrives. The block sits between the on-chip producers and the `data_in_tx`/`tx_en`/`tx_done` ports of `uart_top`.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 8, byte width
- `GAP_CYCLES`, 16, idle clocks enforced after each completed byte (0 allowed)
- `TIMEOUT`, 20000, max clocks in WAIT_DONE before abort (>= one UART frame time)
- `clk`  in  1  system clock, rising-edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  N_REQ  per-requester level request
- `req_data`  in  N_REQ*DATA_W  requester k's byte at bits [k*DATA_W +: DATA_W]
- `ack`  out  N_REQ  one-cycle pulse: requester k's byte completed
- `err`  out  N_REQ  one-cycle pulse: requester k's byte aborted by timeout
- `grant_id`  out  clog2(N_REQ)  index of current/last granted requester
- `busy`  out  1  high in every state except IDLE
- `data_in_tx`  out  DATA_W  byte to transmitter, stable from START until next grant
- `tx_en`  out  1  one-cycle start pulse to transmitter
- `tx_done`  in  1  transmitter completion flag (level or pulse)

## Operation
- States: IDLE, START, WAIT_DONE, GAP.
- IDLE: if `req` != 0, pick the first set bit scanning from `ptr` upward with wrap-around. Register `grant_id`, latch that requester's byte into `data_in_tx`, and go to START.
- START: `tx_en`=1 for exactly this cycle. Set `ptr` = grant_id+1 mod N_REQ. Clear the timeout counter. Go to WAIT_DONE.
- WAIT_DONE: completion event = rising edge of `tx_done` (register `tx_done_q`; event = `tx_done & ~tx_done_q`). A level left high from a previous byte is never a completion.
  - On event: `ack[grant_id]`=1 next cycle, go to GAP.
  - Otherwise increment the counter. When it reaches TIMEOUT-1: `err[grant_id]`=1 next cycle, go to GAP.
  - Event and timeout in the same cycle: event wins, ack only, no err.
- GAP: count GAP_CYCLES clocks, then go to IDLE. If GAP_CYCLES=0, go to IDLE directly from WAIT_DONE's exit cycle (GAP occupies 0 cycles).
- Requests are not consumed or masked by the block. A requester must drop `req` within the cycle after its `ack`/`err`, or it is treated as a new request.
- A requester deasserting `req` or changing `req_data` after grant does not affect the transfer, because the byte is latched. Ack is still issued.
- `ack` and `err` are one-hot or zero. They are never both set.
- Counter widths: timeout counter clog2(TIMEOUT+1), gap counter clog2(GAP_CYCLES+1). No wrap beyond the terminal value.

## Timing
- Reset values: state IDLE, `ptr`=0, `grant_id`=0, `data_in_tx`=0, `tx_en`=0, `ack`=0, `err`=0, `busy`=0, `tx_done_q`=0.
- `rst` asserted in any state returns to IDLE on the next edge with the values above. No ack or err is issued for the aborted byte; `uart_top` shares the same `rst`.
- `req` seen in IDLE at edge t: `grant_id`/`data_in_tx` valid after t, `tx_en` high in cycle t+1.
- `tx_done` rising edge sampled at edge d: `ack` high in cycle d+1, `busy` falls GAP_CYCLES cycles later.
- Back-to-back minimum spacing between `tx_en` pulses = UART frame latency + GAP_CYCLES + 3 clocks.
- All outputs are registered. There is no combinational path from `req`/`tx_done` to outputs.

## Test plan
- Single request: req=4'b0001, byte 8'hA5 -> one `tx_en` pulse, `data_in_tx`=A5, `data_out_rx`=A5 from `uart_top`, `ack`=4'b0001 for one cycle, `busy` low after 16 gap clocks.
- Round-robin: all four requesting with bytes 8'h11/22/33/44 held until ack -> grant order 0,1,2,3. Received bytes 11,22,33,44 with no duplicates.
- Fairness and wrap: ptr at 3 after granting 2; req=4'b1001 -> grant 3 then 0.
- Timeout: `tx_done` tied 0 with TIMEOUT=100 -> `err[k]` pulses 100 clocks after START, no `ack`, returns to IDLE after the gap.
- Stale done level: `tx_done` held high across the START of the next byte -> no early ack; ack occurs only on the next rising edge.
- Reset mid-WAIT_DONE: assert `rst` one cycle -> all outputs zero next cycle, no ack/err, next request is granted to requester 0 first.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// Producer/transmitter-side signals of the UART transmit scheduler.
// master = scheduler, slave = producers plus the transmitter driving tx_done.
interface uart_tx_sched_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        ack;
    logic [N_REQ-1:0]        err;
    logic [IDW-1:0]          grant_id;
    logic                    busy;
    logic [DATA_W-1:0]       data_in_tx;
    logic                    tx_en;
    logic                    tx_done;

    modport master (
        input  req, req_data, tx_done,
        output ack, err, grant_id, busy, data_in_tx, tx_en
    );

    modport slave (
        output req, req_data, tx_done,
        input  ack, err, grant_id, busy, data_in_tx, tx_en
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ producers,
// with completion edge detection, per-byte watchdog and an enforced idle gap.
module uart_tx_sched #(
    parameter int N_REQ      = 4,
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 20000
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_sched_if.master bus
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int GW  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

    state_t            state_q;
    logic [IDW-1:0]    ptr_q;
    logic [IDW-1:0]    grant_id_q;
    logic [IDW-1:0]    grant_d;
    logic              found_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] byte_d;
    logic [N_REQ-1:0]  ack_q;
    logic [N_REQ-1:0]  err_q;
    logic [N_REQ-1:0]  onehot;
    logic              tx_en_q;
    logic              busy_q;
    logic              tx_done_q;
    logic              done_evt;
    logic              tmo_hit;
    logic [TW-1:0]     tmo_q;
    logic [TW-1:0]     tmo_inc;
    logic [GW-1:0]     gap_q;
    logic [DATA_W-1:0] req_byte [N_REQ];
    int unsigned       scan_idx;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_byte[g] = bus.req_data[g*DATA_W +: DATA_W];
    end

    // First requester at or after ptr_q, wrapping round.
    always_comb begin
        found_d  = 1'b0;
        grant_d  = '0;
        scan_idx = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan_idx = (32'(ptr_q) + i) % N_REQ;
            if (!found_d && bus.req[IDW'(scan_idx)]) begin
                found_d = 1'b1;
                grant_d = IDW'(scan_idx);
            end
        end
    end

    assign byte_d   = req_byte[grant_d];
    assign onehot   = N_REQ'(1) << grant_id_q;
    assign done_evt = bus.tx_done & ~tx_done_q;
    assign tmo_inc  = tmo_q + 1'b1;
    assign tmo_hit  = (tmo_inc == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            data_q     <= '0;
            ack_q      <= '0;
            err_q      <= '0;
            tx_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
            tmo_q      <= '0;
            gap_q      <= '0;
        end else begin
            tx_done_q <= bus.tx_done;
            ack_q     <= '0;
            err_q     <= '0;
            tx_en_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        grant_id_q <= grant_d;
                        data_q     <= byte_d;
                        tx_en_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (grant_id_q == IDW'(N_REQ - 1)) ptr_q <= '0;
                    else                               ptr_q <= grant_id_q + 1'b1;
                    tmo_q   <= '0;
                    state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // A completion edge on the watchdog's last cycle still counts as success.
                    if (done_evt || tmo_hit) begin
                        if (done_evt) ack_q <= onehot;
                        else          err_q <= onehot;
                        gap_q <= '0;
                        if (GAP_CYCLES == 0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= GAP;
                        end
                    end else begin
                        tmo_q <= tmo_inc;
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ack        = ack_q;
    assign bus.err        = err_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.busy       = busy_q;
    assign bus.data_in_tx = data_q;
    assign bus.tx_en      = tx_en_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: timestamp-based reference model checked every cycle,
// a simple transmitter stand-in, and directed scenarios with literal expectations.
module tb_uart_tx_sched;
    localparam int N       = 4;
    localparam int DW      = 8;
    localparam int GAP     = 16;
    localparam int TMO     = 100;
    localparam int FRAME   = 30;
    localparam int M_PULSE = 0;
    localparam int M_LEVEL = 1;
    localparam int M_DEAD  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_sched_if #(.N_REQ(N), .DATA_W(DW)) bus ();

    uart_tx_sched #(
        .N_REQ(N), .DATA_W(DW), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] b [4];
    int mode = M_PULSE;
    int cyc = 0, frame_cnt = 0, hold_cnt = 0;
    int txen_cyc = 0, ack_cyc = 0, err_cyc = 0, fall_cyc = 0;
    logic busy_prev = 1'b0;
    int gq[$], rxq[$], ackq[$], errq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_list(input string name, input int q[$], input int n,
                              input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        check({name, "_len"}, 32'(q.size()), 32'(n));
        for (int i = 0; i < n && i < q.size(); i++) check(name, 32'(q[i]), 32'(e[i]));
    endtask

    // Reference model: expected outputs for the cycle after each edge.
    logic       mvalid = 1'b0;
    logic       e_txen = 1'b0, e_busy = 1'b0;
    int         e_ack = 0, e_err = 0, e_grant = 0;
    logic [7:0] e_data = '0;
    int         m_now = 0, m_ptr = 0, m_start = 0, m_idle_at = 0;
    logic       m_wait = 1'b0, m_done_q = 1'b0;

    always @(posedge clk) begin
        logic [3:0] rq;
        logic       hit;
        int         c, g;
        e_txen = 1'b0;
        e_ack  = 0;
        e_err  = 0;
        if (rst) begin
            mvalid    = 1'b1;
            m_ptr     = 0;
            e_grant   = 0;
            e_data    = '0;
            m_wait    = 1'b0;
            m_idle_at = m_now + 1;
            m_done_q  = 1'b0;
        end else if (mvalid) begin
            rq = bus.req;
            if (!m_wait && m_now >= m_idle_at && rq != 0) begin
                hit = 1'b0;
                g = 0;
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (!hit && rq[c[1:0]]) begin hit = 1'b1; g = c; end
                end
                e_grant = g;
                e_data  = b[g[1:0]];
                m_ptr   = (g + 1) % N;
                m_start = m_now + 1;
                m_wait  = 1'b1;
                e_txen  = 1'b1;
            end else if (m_wait && m_now >= m_start + 1) begin
                if (bus.tx_done && !m_done_q) begin
                    e_ack = 1 << e_grant;
                    m_wait = 1'b0;
                    m_idle_at = m_now + 1 + GAP;
                end else if (m_now == m_start + TMO - 1) begin
                    e_err = 1 << e_grant;
                    m_wait = 1'b0;
                    m_idle_at = m_now + 1 + GAP;
                end
            end
            m_done_q = bus.tx_done;
        end
        e_busy = m_wait || (m_now + 1 < m_idle_at);
        m_now++;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mvalid) begin
                check("tx_en",      32'(bus.tx_en),      32'(e_txen));
                check("ack",        32'(bus.ack),        e_ack);
                check("err",        32'(bus.err),        e_err);
                check("busy",       32'(bus.busy),       32'(e_busy));
                check("grant_id",   32'(bus.grant_id),   e_grant);
                check("data_in_tx", 32'(bus.data_in_tx), 32'(e_data));
            end
        end
    end

    // Transmitter stand-in, producer request drop, and event logging; runs once per cycle.
    task automatic env_update();
        if (rst) begin
            frame_cnt   = 0;
            hold_cnt    = 0;
            bus.tx_done = 1'b0;
            busy_prev   = 1'b0;
            return;
        end
        if (bus.ack != 0) begin ackq.push_back(int'(bus.ack)); ack_cyc = cyc; end
        if (bus.err != 0) begin errq.push_back(int'(bus.err)); err_cyc = cyc; end
        if (busy_prev && !bus.busy) fall_cyc = cyc;
        busy_prev = bus.busy;
        bus.req = bus.req & ~(bus.ack | bus.err);
        if (bus.tx_en) begin
            rxq.push_back(int'(bus.data_in_tx));
            gq.push_back(int'(bus.grant_id));
            txen_cyc  = cyc;
            frame_cnt = FRAME;
            hold_cnt  = (mode == M_LEVEL) ? 5 : 0;
        end else begin
            if (mode == M_PULSE && bus.tx_done) bus.tx_done = 1'b0;
            if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) bus.tx_done = 1'b0;
            end
            if (frame_cnt > 0) begin
                frame_cnt--;
                if (frame_cnt == 0 && mode != M_DEAD) bus.tx_done = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        env_update();
    endtask

    task automatic drive_req(input logic [3:0] m);
        bus.req_data = {b[3], b[2], b[1], b[0]};
        bus.req      = m;
    endtask

    task automatic clear_logs();
        gq.delete(); rxq.delete(); ackq.delete(); errq.delete();
    endtask

    task automatic wait_quiet(input int maxc, input string name);
        int n = 0;
        step();
        while ((bus.req != 0 || bus.busy) && n < maxc) begin step(); n++; end
        check({name, "_quiet"}, 32'(n < maxc), 32'd1);
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_busy"},  32'(bus.busy),       32'd0);
        check({name, "_tx_en"}, 32'(bus.tx_en),      32'd0);
        check({name, "_ack"},   32'(bus.ack),        32'd0);
        check({name, "_err"},   32'(bus.err),        32'd0);
        check({name, "_grant"}, 32'(bus.grant_id),   32'd0);
        check({name, "_data"},  32'(bus.data_in_tx), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        for (int i = 0; i < 4; i++) b[i] = '0;
        bus.req = '0;
        bus.req_data = '0;
        bus.tx_done = 1'b0;
        repeat (3) step();
        check_zero_outputs("reset");
        rst = 1'b0;

        // Single request
        clear_logs();
        b[0] = 8'hA5;
        drive_req(4'b0001);
        wait_quiet(300, "single");
        check_list("single_grant", gq, 1, 0, 0, 0, 0);
        check_list("single_rx", rxq, 1, 'hA5, 0, 0, 0);
        check_list("single_ack", ackq, 1, 'b0001, 0, 0, 0);
        check_list("single_err", errq, 0, 0, 0, 0, 0);
        check("single_ack_lat", 32'(ack_cyc - txen_cyc), 32'd31);
        check("single_gap", 32'(fall_cyc - ack_cyc), 32'd16);

        // Round-robin from a fresh reset
        rst = 1'b1; step(); rst = 1'b0;
        clear_logs();
        b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
        drive_req(4'b1111);
        wait_quiet(1000, "rr");
        check_list("rr_grant", gq, 4, 0, 1, 2, 3);
        check_list("rr_rx", rxq, 4, 'h11, 'h22, 'h33, 'h44);
        check_list("rr_ack", ackq, 4, 1, 2, 4, 8);

        // Wrap: grant 2 leaves ptr at 3, then 1001 -> 3 then 0
        clear_logs();
        b[2] = 8'h5C;
        drive_req(4'b0100);
        wait_quiet(300, "wrap_a");
        b[0] = 8'hC0; b[3] = 8'h3C;
        drive_req(4'b1001);
        wait_quiet(600, "wrap_b");
        check_list("wrap_grant", gq, 3, 2, 3, 0, 0);
        check_list("wrap_rx", rxq, 3, 'h5C, 'h3C, 'hC0, 0);

        // Timeout with no completion
        clear_logs();
        mode = M_DEAD;
        b[1] = 8'h7E;
        drive_req(4'b0010);
        wait_quiet(400, "tmo");
        check_list("tmo_err", errq, 1, 'b0010, 0, 0, 0);
        check_list("tmo_ack", ackq, 0, 0, 0, 0, 0);
        check("tmo_lat", 32'(err_cyc - txen_cyc), 32'd100);
        check("tmo_gap", 32'(fall_cyc - err_cyc), 32'd16);

        // Stale done level across the next START
        clear_logs();
        mode = M_LEVEL;
        b[0] = 8'h96;
        drive_req(4'b0001);
        wait_quiet(300, "stale_a");
        check("stale_a_lat", 32'(ack_cyc - txen_cyc), 32'd31);
        check("stale_level_high", 32'(bus.tx_done), 32'd1);
        b[2] = 8'h69;
        drive_req(4'b0100);
        wait_quiet(300, "stale_b");
        check("stale_b_lat", 32'(ack_cyc - txen_cyc), 32'd31);
        check_list("stale_ack", ackq, 2, 'b0001, 'b0100, 0, 0);
        check_list("stale_grant", gq, 2, 0, 2, 0, 0);
        mode = M_PULSE;
        bus.tx_done = 1'b0;

        // Reset in WAIT_DONE
        clear_logs();
        b[2] = 8'hE1;
        drive_req(4'b0100);
        n = 0;
        while (gq.size() == 0 && n < 20) begin step(); n++; end
        check("rstw_started", 32'(gq.size()), 32'd1);
        repeat (5) step();
        rst = 1'b1;
        b[0] = 8'h0F; b[3] = 8'hF0;
        drive_req(4'b1101);
        step();
        check_zero_outputs("rstw");
        rst = 1'b0;
        wait_quiet(1000, "rstw");
        check_list("rstw_grant", gq, 4, 2, 0, 2, 3);
        check_list("rstw_rx", rxq, 4, 'hE1, 'h0F, 'hE1, 'hF0);
        check_list("rstw_ack", ackq, 3, 1, 4, 8, 0);
        check_list("rstw_err", errq, 0, 0, 0, 0, 0);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
